rx_frame_assembler: RTL
=======================

Name: rx_frame_assembler

Overview:
Parametrised byte-stream frame assembler for the UART calculator path. It collects N_OPS operands of OP_BYTES bytes each (LSB first), then one command byte, from the UART receiver. It commits all fields atomically to clocked output registers and pulses a trigger to start the TX-result path. It replaces the fixed 2-operand/16-bit receive controller and adds an inter-byte timeout, overrun detection and atomic update.

Parameters:
N_OPS, 2, number of operands per frame (1..8)
OP_BYTES, 2, bytes per operand (1..4); operand width OPW = 8*OP_BYTES
CMD_WIDTH, 2, command bits taken from rx_data[CMD_WIDTH-1:0] (1..8)
TIMEOUT_CYCLES, 100000, idle cycles allowed between bytes inside a frame; 0 disables timeout

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
rx_valid  in  1  one-cycle pulse: rx_data holds a received byte
rx_data  in  8  received byte
ops  out  N_OPS*OPW  committed operands, op k at [k*OPW +: OPW]
cmd  out  CMD_WIDTH  committed command
trigger  out  1  one-cycle pulse requesting result transmission
show_result  out  1  high while the committed result is current
busy  out  1  high while a frame is partially received or being committed
byte_idx  out  $clog2(N_OPS*OP_BYTES+1)  bytes accepted in the current frame
timeout_err  out  1  one-cycle pulse: partial frame discarded on timeout
overrun_err  out  1  one-cycle pulse: byte arrived during COMMIT/DELAY/TRIG and was dropped

Behaviour:
- Reset (async) values: state=IDLE; ops=0, cmd=0, shadow=0, byte_idx=0; trigger, busy, timeout_err, overrun_err=0; show_result=1.
- All outputs are registered. Update happens only on the clk rising edge.
- Frame length F = N_OPS*OP_BYTES + 1 bytes. Byte i<F-1 goes to operand i/OP_BYTES, byte lane i%OP_BYTES (lane 0 = LSB). Byte F-1 is the command.
- States:
  - IDLE: on rx_valid, write the byte to shadow lane 0, set byte_idx=1, show_result=0, and go to COLLECT. If F-1==0 this byte is not possible, because N_OPS>=1.
  - COLLECT: on rx_valid, write the shadow lane at byte_idx and increment byte_idx. When the accepted byte is index F-2 (the last operand byte), go to CMD.
  - CMD: on rx_valid, latch shadow_cmd=rx_data[CMD_WIDTH-1:0] and go to COMMIT.
  - COMMIT (1 cycle): copy ops<=shadow ops and cmd<=shadow_cmd in the same edge; set show_result=1, byte_idx=0; go to DELAY.
  - DELAY (1 cycle): go to TRIG.
  - TRIG (1 cycle): trigger=1; go to IDLE.
- Latency: the cmd byte accepted at edge N produces ops/cmd valid after edge N+1 and trigger high during the cycle after edge N+3.
- busy = (state != IDLE).
- Timeout: a counter clears on every accepted byte and on entry to COLLECT. It counts while in COLLECT or CMD. When it reaches TIMEOUT_CYCLES with no rx_valid:
  - discard the shadow and set byte_idx=0;
  - pulse timeout_err for 1 cycle;
  - return to IDLE;
  - leave ops/cmd unchanged and set show_result=1 (the old result is still current).
  - If rx_valid and the timeout coincide on the same edge, the byte wins and the counter clears.
- Overrun: rx_valid in COMMIT/DELAY/TRIG drops the byte and pulses overrun_err for 1 cycle. The state sequence is unaffected.
- Committed ops/cmd change only in COMMIT. A partial frame never alters the outputs.
- Reset mid-frame aborts immediately: outputs go to their reset values and no trigger is issued.
- Unused/illegal state encodings: go to IDLE with no output side effects.

Test Plan:
- Default params, bytes 0x34,0x12,0x78,0x56,0x02 spaced 10 cycles -> ops[15:0]=0x1234, ops[31:16]=0x5678, cmd=2 one edge after the cmd byte; single trigger pulse 3 edges after the cmd byte; byte_idx steps 1..4 then 0.
- Default params, send 0xAA,0xBB then idle TIMEOUT_CYCLES (override to 50) -> timeout_err pulse at cycle 50 after 0xBB; ops/cmd keep previous frame values; next 5-byte frame assembles correctly from byte lane 0.
- Frame completed, then rx_valid pulse 1 cycle after the cmd byte (during COMMIT) -> overrun_err=1 for 1 cycle; byte not stored; trigger still fires; following frame starts clean.
- N_OPS=3, OP_BYTES=1, CMD_WIDTH=3, bytes 0x01,0x02,0x03,0xFF -> ops=0x030201, cmd=3'b111, exactly one trigger.
- Assert reset for 2 cycles after 3 bytes of a default frame -> all outputs at reset values, no trigger; subsequent full frame commits normally.
- rx_valid on the exact cycle the timeout expires (TIMEOUT_CYCLES=20) -> byte accepted, no timeout_err, byte_idx increments.

Source files
------------

// File: rtl/rx_frame_assembler.sv
// rx_frame_assembler
// Collects N_OPS operands of OP_BYTES bytes each (LSB first) followed by one
// command byte from the UART receiver, commits them atomically to the output
// registers and pulses trigger to start the TX-result path.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   rx_valid     one-cycle pulse, rx_data holds a received byte
//   rx_data      received byte
//   ops          committed operands, op k at [k*OPW +: OPW]
//   cmd          committed command (rx_data[CMD_WIDTH-1:0] of the last byte)
//   trigger      one-cycle pulse requesting result transmission
//   show_result  high while the committed result is current
//   busy         high while a frame is partially received or being committed
//   byte_idx     bytes accepted in the current frame
//   timeout_err  one-cycle pulse, partial frame discarded on inter-byte timeout
//   overrun_err  one-cycle pulse, byte dropped during COMMIT/DELAY/TRIG
module rx_frame_assembler #(
    parameter int unsigned N_OPS          = 2,
    parameter int unsigned OP_BYTES       = 2,
    parameter int unsigned CMD_WIDTH      = 2,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 rx_valid,
    input  logic [7:0]                           rx_data,
    output logic [N_OPS*8*OP_BYTES-1:0]          ops,
    output logic [CMD_WIDTH-1:0]                 cmd,
    output logic                                 trigger,
    output logic                                 show_result,
    output logic                                 busy,
    output logic [$clog2(N_OPS*OP_BYTES+1)-1:0]  byte_idx,
    output logic                                 timeout_err,
    output logic                                 overrun_err
);

    localparam int unsigned NB   = N_OPS * OP_BYTES;
    localparam int unsigned IDXW = $clog2(NB + 1);
    localparam int unsigned LAST = NB - 1;
    localparam int unsigned TW   = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_CMD     = 3'd2,
        S_COMMIT  = 3'd3,
        S_DELAY   = 3'd4,
        S_TRIG    = 3'd5
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [NB*8-1:0]        shadow;
    logic [NB*8-1:0]        shadow_next;
    logic [CMD_WIDTH-1:0]   shadow_cmd;
    logic [CMD_WIDTH-1:0]   shadow_cmd_next;
    logic [NB*8-1:0]        ops_next;
    logic [CMD_WIDTH-1:0]   cmd_next;
    logic [IDXW-1:0]        idx_next;
    logic                   show_next;
    logic                   trigger_next;
    logic                   busy_next;
    logic                   timeout_next;
    logic                   overrun_next;
    logic [TW-1:0]          tmo_cnt;
    logic [TW-1:0]          tmo_cnt_next;
    logic                   tmo_hit_c;

    // Expiry fires on the edge where the idle count reaches TIMEOUT_CYCLES.
    assign tmo_hit_c = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            shadow      <= '0;
            shadow_cmd  <= '0;
            ops         <= '0;
            cmd         <= '0;
            byte_idx    <= '0;
            show_result <= 1'b1;
            trigger     <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            overrun_err <= 1'b0;
            tmo_cnt     <= '0;
        end else begin
            state       <= state_next;
            shadow      <= shadow_next;
            shadow_cmd  <= shadow_cmd_next;
            ops         <= ops_next;
            cmd         <= cmd_next;
            byte_idx    <= idx_next;
            show_result <= show_next;
            trigger     <= trigger_next;
            busy        <= busy_next;
            timeout_err <= timeout_next;
            overrun_err <= overrun_next;
            tmo_cnt     <= tmo_cnt_next;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_next      = state;
        shadow_next     = shadow;
        shadow_cmd_next = shadow_cmd;
        ops_next        = ops;
        cmd_next        = cmd;
        idx_next        = byte_idx;
        show_next       = show_result;
        trigger_next    = 1'b0;
        timeout_next    = 1'b0;
        overrun_next    = 1'b0;
        tmo_cnt_next    = tmo_cnt;

        case (state)
            S_IDLE: begin
                if (rx_valid) begin
                    shadow_next[7:0] = rx_data;
                    idx_next         = IDXW'(1);
                    show_next        = 1'b0;
                    tmo_cnt_next     = '0;
                    // A single-byte operand field goes straight to the command byte.
                    state_next       = (NB == 1) ? S_CMD : S_COLLECT;
                end
            end

            S_COLLECT: begin
                if (rx_valid) begin
                    for (int unsigned i = 0; i < NB; i++) begin
                        if (byte_idx == IDXW'(i)) begin
                            shadow_next[i*8 +: 8] = rx_data;
                        end
                    end
                    idx_next     = byte_idx + IDXW'(1);
                    tmo_cnt_next = '0;
                    if (byte_idx == IDXW'(LAST)) begin
                        state_next = S_CMD;
                    end
                end else if (tmo_hit_c) begin
                    shadow_next     = '0;
                    shadow_cmd_next = '0;
                    idx_next        = '0;
                    show_next       = 1'b1;
                    timeout_next    = 1'b1;
                    tmo_cnt_next    = '0;
                    state_next      = S_IDLE;
                end else if (TIMEOUT_CYCLES != 0) begin
                    tmo_cnt_next = tmo_cnt + TW'(1);
                end
            end

            S_CMD: begin
                if (rx_valid) begin
                    shadow_cmd_next = rx_data[CMD_WIDTH-1:0];
                    tmo_cnt_next    = '0;
                    state_next      = S_COMMIT;
                end else if (tmo_hit_c) begin
                    shadow_next     = '0;
                    shadow_cmd_next = '0;
                    idx_next        = '0;
                    show_next       = 1'b1;
                    timeout_next    = 1'b1;
                    tmo_cnt_next    = '0;
                    state_next      = S_IDLE;
                end else if (TIMEOUT_CYCLES != 0) begin
                    tmo_cnt_next = tmo_cnt + TW'(1);
                end
            end

            // All committed fields update on the same edge.
            S_COMMIT: begin
                ops_next     = shadow;
                cmd_next     = shadow_cmd;
                show_next    = 1'b1;
                idx_next     = '0;
                overrun_next = rx_valid;
                state_next   = S_DELAY;
            end

            S_DELAY: begin
                overrun_next = rx_valid;
                state_next   = S_TRIG;
            end

            S_TRIG: begin
                trigger_next = 1'b1;
                overrun_next = rx_valid;
                state_next   = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase

        busy_next = (state_next != S_IDLE);
    end

endmodule
